// File: rtl/ysyx_22050518_axi_pkg.sv
// Shared AXI4 constants and FSM state type for the core-side AXI master bridge.
package ysyx_22050518_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned AXI_ID_DEFAULT = 0;

    // Requests are never exclusive, so anything other than OKAY is a failure.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic w_err;
        w_err = 1'b1;
        case (resp)
            RESP_OKAY:                              w_err = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR:  w_err = 1'b1;
            default:                                w_err = 1'b1;
        endcase
        return w_err;
    endfunction

endpackage

// File: rtl/axi4_master_bridge_if.sv
// Single-beat AXI4 bus between the bridge (master) and the SoC responder (slave).
interface axi4_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) ();

    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [2:0]        awsize;
    logic [7:0]        awlen;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [2:0]        arsize;
    logic [7:0]        arlen;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;
    logic [DATA_W-1:0] rdata;

    modport master (
        output awvalid, awaddr, awid, awsize, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arsize, arlen, arburst,
        input  arready,
        input  rvalid, rid, rresp, rlast, rdata,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awsize, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arsize, arlen, arburst,
        output arready,
        output rvalid, rid, rresp, rlast, rdata,
        input  rready
    );

endinterface

// File: rtl/axi4_master_bridge.sv
// Turns one outstanding core memory request into a single-beat AXI4 read or write
// and returns the result as a one-cycle response pulse.
module axi4_master_bridge
    import ysyx_22050518_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned AXI_ID = AXI_ID_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [2:0]           req_size,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_wstrb,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    axi4_master_bridge_if.master io_master
);

    localparam logic [ID_W-1:0] ID_VAL = ID_W'(AXI_ID);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_size;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_aw_done;
    logic                r_w_done;

    logic w_req_ready;
    logic w_arvalid;
    logic w_rready;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;
    logic w_accept;
    logic w_r_hs;
    logic w_b_hs;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_ready   = 1'b0;
        w_arvalid     = 1'b0;
        w_rready      = 1'b0;
        w_awvalid     = 1'b0;
        w_wvalid      = 1'b0;
        w_bready      = 1'b0;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = req_we ? StWrReq : StRdAddr;
                end
            end
            StRdAddr: begin
                w_arvalid = 1'b1;
                if (io_master.arready) begin
                    w_state_nxt = StRdData;
                end
            end
            StRdData: begin
                w_rready = 1'b1;
                if (io_master.rvalid) begin
                    w_state_nxt = StIdle;
                end
            end
            StWrReq: begin
                // AW and W retire independently; leave only once both have handshaken.
                w_awvalid     = !r_aw_done;
                w_wvalid      = !r_w_done;
                w_aw_done_nxt = r_aw_done || io_master.awready;
                w_w_done_nxt  = r_w_done || io_master.wready;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = StWrResp;
                end
            end
            StWrResp: begin
                w_bready = 1'b1;
                if (io_master.bvalid) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_accept = w_req_ready && req_valid;
    assign w_r_hs   = w_rready && io_master.rvalid;
    assign w_b_hs   = w_bready && io_master.bvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            if (w_accept) begin
                r_addr    <= req_addr;
                r_size    <= req_size;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_r_hs) begin
                r_rdata     <= io_master.rdata;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= resp_is_err(io_master.rresp) || (io_master.rid != ID_VAL)
                               || !io_master.rlast;
            end
            if (w_b_hs) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= resp_is_err(io_master.bresp) || (io_master.bid != ID_VAL);
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;

    assign io_master.arvalid = w_arvalid;
    assign io_master.araddr  = r_addr;
    assign io_master.arid    = ID_VAL;
    assign io_master.arsize  = r_size;
    assign io_master.arlen   = 8'd0;
    assign io_master.arburst = BURST_INCR;
    assign io_master.rready  = w_rready;

    assign io_master.awvalid = w_awvalid;
    assign io_master.awaddr  = r_addr;
    assign io_master.awid    = ID_VAL;
    assign io_master.awsize  = r_size;
    assign io_master.awlen   = 8'd0;
    assign io_master.awburst = BURST_INCR;

    assign io_master.wvalid  = w_wvalid;
    assign io_master.wdata   = r_wdata;
    assign io_master.wstrb   = r_wstrb;
    assign io_master.wlast   = w_wvalid;

    assign io_master.bready  = w_bready;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Scoreboard bench: directed requests push expected responses, a monitor pops them on rsp_valid.
module tb_axi4_master_bridge;
    import ysyx_22050518_axi_pkg::*;

    typedef struct {
        bit          is_rd;
        logic [63:0] rdata;
        bit          err;
        int          lat;
        int          t0;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    axi4_master_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

    axi4_master_bridge #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .AXI_ID(0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .io_master (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    // Responder configuration and state
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic [1:0]  cfg_rresp = RESP_OKAY, cfg_bresp = RESP_OKAY;
    logic [3:0]  cfg_rid = 4'd0, cfg_bid = 4'd0;
    logic        cfg_rlast = 1'b1;
    bit          cfg_b_hold = 1'b0;
    logic        force_b = 1'b0;
    logic        rs_rvalid = 1'b0, rs_bvalid = 1'b0;
    logic [63:0] rs_rdata = '0;
    bit          aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_strb = '0;
    logic [63:0] rs_mem  [logic [28:0]];
    logic [63:0] ref_mem [logic [28:0]];

    // Observed bus history
    logic [31:0] last_araddr = '0, last_awaddr = '0;
    logic [7:0]  last_arlen = '0;
    logic [1:0]  last_arburst = '0;
    logic [2:0]  last_arsize = '0, last_awsize = '0;
    logic [3:0]  last_arid = '0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_wstrb = '0;
    logic        last_wlast = 1'b0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, aw_hi = 0, w_hi = 0, ar_total = 0, aw_total = 0;

    assign bus.arready = bus.arvalid && (ar_cnt >= ar_wait);
    assign bus.awready = bus.awvalid && (aw_cnt >= aw_wait);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_wait);
    assign bus.rvalid  = rs_rvalid;
    assign bus.rdata   = rs_rdata;
    assign bus.rid     = cfg_rid;
    assign bus.rresp   = cfg_rresp;
    assign bus.rlast   = cfg_rlast;
    assign bus.bvalid  = rs_bvalid || force_b;
    assign bus.bid     = cfg_bid;
    assign bus.bresp   = cfg_bresp;

    initial begin
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] ws);
        logic [63:0] v;
        v = old;
        for (int b = 0; b < 8; b++) begin
            if (ws[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic [63:0] rs_rd(input logic [31:0] a);
        return rs_mem.exists(a[31:3]) ? rs_mem[a[31:3]] : 64'd0;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:3]) ? ref_mem[a[31:3]] : 64'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: sample handshakes at the edge, drive new values 1 time unit later.
    initial begin
        bit s_rst, s_ar, s_aw, s_w, s_r, s_b, s_arv, s_awv, s_wv;
        forever begin
            @(posedge clock);
            s_rst = reset;
            s_arv = bus.arvalid;
            s_awv = bus.awvalid;
            s_wv  = bus.wvalid;
            s_ar  = bus.arvalid && bus.arready;
            s_aw  = bus.awvalid && bus.awready;
            s_w   = bus.wvalid && bus.wready;
            s_r   = bus.rvalid && bus.rready;
            s_b   = bus.bvalid && bus.bready;
            if (s_ar) begin
                last_araddr  = bus.araddr;
                last_arlen   = bus.arlen;
                last_arburst = bus.arburst;
                last_arsize  = bus.arsize;
                last_arid    = bus.arid;
                ar_total++;
            end
            if (s_aw) begin
                last_awaddr = bus.awaddr;
                last_awsize = bus.awsize;
                aw_hs_cyc   = cyc;
                aw_total++;
            end
            if (s_w) begin
                last_wdata = bus.wdata;
                last_wstrb = bus.wstrb;
                last_wlast = bus.wlast;
                w_hs_cyc   = cyc;
            end
            if (s_awv) aw_hi++;
            if (s_wv)  w_hi++;
            cyc++;
            #1;
            if (s_rst) begin
                rs_rvalid = 1'b0;
                rs_bvalid = 1'b0;
                aw_got = 1'b0;
                w_got  = 1'b0;
                ar_cnt = 0;
                aw_cnt = 0;
                w_cnt  = 0;
            end else begin
                ar_cnt = (s_arv && !s_ar) ? ar_cnt + 1 : 0;
                aw_cnt = (s_awv && !s_aw) ? aw_cnt + 1 : 0;
                w_cnt  = (s_wv && !s_w) ? w_cnt + 1 : 0;
                if (s_r) rs_rvalid = 1'b0;
                if (s_ar) begin
                    rs_rvalid = 1'b1;
                    rs_rdata  = rs_rd(last_araddr);
                end
                if (s_b) rs_bvalid = 1'b0;
                if (s_aw) begin
                    aw_got  = 1'b1;
                    wr_addr = last_awaddr;
                end
                if (s_w) begin
                    w_got   = 1'b1;
                    wr_data = last_wdata;
                    wr_strb = last_wstrb;
                end
                if (aw_got && w_got) begin
                    rs_mem[wr_addr[31:3]] = merge(rs_rd(wr_addr), wr_data, wr_strb);
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                    if (!cfg_b_hold) rs_bvalid = 1'b1;
                end
            end
        end
    end

    // Monitor: every rsp_valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)",
                             cyc);
                end else begin
                    e = q.pop_front();
                    if (e.is_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.t0), 64'(e.lat));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge with req_valid low.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] wd, input logic [7:0] ws, input bit err,
                         input int lat, input bit push, output int t0);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wd;
        req_wstrb = ws;
        t0 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=0, want 1 within 200 cycles");
        end else begin
            e.is_rd = !we;
            e.rdata = ref_rd(addr);
            e.err   = err;
            e.lat   = lat;
            e.t0    = t0;
            if (we) ref_mem[addr[31:3]] = merge(ref_rd(addr), wd, ws);
            if (push) q.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(negedge clock);
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_arvalid"},   64'(bus.arvalid), 64'd0);
        chk({tag, "_awvalid"},   64'(bus.awvalid), 64'd0);
        chk({tag, "_wvalid"},    64'(bus.wvalid), 64'd0);
        chk({tag, "_rready"},    64'(bus.rready), 64'd0);
        chk({tag, "_bready"},    64'(bus.bready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int t0, prev_t0, ar0, aw0;
        bit we;
        logic [31:0] a;

        rs_mem[29'h1000_0002]  = 64'h1122_3344_5566_7788;
        ref_mem[29'h1000_0002] = 64'h1122_3344_5566_7788;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_idle("reset");
        chk("reset_rsp_err",   64'(rsp_err), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_araddr",    64'(bus.araddr), 64'd0);
        chk("reset_wdata",     bus.wdata, 64'd0);
        chk("reset_wstrb",     64'(bus.wstrb), 64'd0);
        step();
        reset = 1'b0;

        // Zero-wait read
        step();
        issue(1'b0, 32'h8000_0010, 3'd3, '0, '0, 1'b0, 3, 1'b1, t0);
        drain();
        chk("rd_araddr",  64'(last_araddr), 64'h8000_0010);
        chk("rd_arlen",   64'(last_arlen), 64'd0);
        chk("rd_arburst", 64'(last_arburst), 64'd1);
        chk("rd_arsize",  64'(last_arsize), 64'd3);
        chk("rd_arid",    64'(last_arid), 64'd0);

        // Write with W accepted at cycle 1 and AW held until cycle 4
        step();
        aw_wait = 3;
        aw_hi = 0;
        w_hi = 0;
        issue(1'b1, 32'h8000_0020, 3'd2, 64'hDEAD_BEEF, 8'h0F, 1'b0, 6, 1'b1, t0);
        drain();
        chk("wr_w_hs_cycle",  64'(w_hs_cyc - t0), 64'd1);
        chk("wr_aw_hs_cycle", 64'(aw_hs_cyc - t0), 64'd4);
        chk("wr_wvalid_cycles",  64'(w_hi), 64'd1);
        chk("wr_awvalid_cycles", 64'(aw_hi), 64'd4);
        chk("wr_awaddr", 64'(last_awaddr), 64'h8000_0020);
        chk("wr_awsize", 64'(last_awsize), 64'd2);
        chk("wr_wdata",  last_wdata, 64'hDEAD_BEEF);
        chk("wr_wstrb",  64'(last_wstrb), 64'h0F);
        chk("wr_wlast",  64'(last_wlast), 64'd1);
        step();
        aw_wait = 0;

        // Error responses
        cfg_rresp = RESP_SLVERR;
        issue(1'b0, 32'h8000_0010, 3'd3, '0, '0, 1'b1, 3, 1'b1, t0);
        drain();
        step();
        cfg_rresp = RESP_OKAY;
        cfg_bresp = RESP_DECERR;
        issue(1'b1, 32'h8000_0028, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 3, 1'b1, t0);
        drain();
        step();
        cfg_bresp = RESP_OKAY;
        cfg_rid = 4'd5;
        issue(1'b0, 32'h8000_0020, 3'd3, '0, '0, 1'b1, 3, 1'b1, t0);
        drain();
        step();
        cfg_rid = 4'd0;
        cfg_rlast = 1'b0;
        issue(1'b0, 32'h8000_0028, 3'd3, '0, '0, 1'b1, 3, 1'b1, t0);
        drain();
        step();
        cfg_rlast = 1'b1;
        issue(1'b0, 32'h8000_0028, 3'd3, '0, '0, 1'b0, 3, 1'b1, t0);
        drain();

        // AR backpressure with a competing request held high
        step();
        ar_wait = 10;
        ar0 = ar_total;
        aw0 = aw_total;
        issue(1'b0, 32'h8000_0044, 3'd1, '0, '0, 1'b0, 13, 1'b1, t0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h9000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_arvalid",   64'(bus.arvalid), 64'd1);
            chk("bp_araddr",    64'(bus.araddr), 64'h8000_0044);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        step();
        req_valid = 1'b0;
        drain();
        chk("bp_ar_count", 64'(ar_total - ar0), 64'd1);
        chk("bp_aw_count", 64'(aw_total - aw0), 64'd0);
        step();
        ar_wait = 0;

        // Reset while waiting for B; a late bvalid must not complete anything
        cfg_b_hold = 1'b1;
        issue(1'b1, 32'h8000_0050, 3'd3, 64'h5555_AAAA_5555_AAAA, 8'hFF, 1'b0, 3, 1'b0, t0);
        step();
        @(negedge clock);
        chk("wresp_bready", 64'(bus.bready), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk_idle("post_reset");
        step();
        force_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("late_b_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("late_b_bready",    64'(bus.bready), 64'd0);
        end
        step();
        force_b = 1'b0;
        cfg_b_hold = 1'b0;

        // Back-to-back random traffic against a zero-wait responder
        prev_t0 = 0;
        for (int i = 0; i < 100; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'h8000_0000 + 32'($urandom_range(0, 31) * 8) + 32'($urandom_range(0, 7));
            issue(we, a, 3'($urandom_range(0, 3)), {$urandom, $urandom},
                  8'($urandom_range(0, 255)), 1'b0, 3, 1'b1, t0);
            if (i > 0) chk("b2b_accept_spacing", 64'(t0 - prev_t0), 64'd3);
            prev_t0 = t0;
        end
        drain();
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4_master_bridge.md
Name: axi4_master_bridge

Overview:
Converts the core's single-request memory port into single-beat AXI4 transactions on the io_master_* bus toward the SoC responder.
It accepts one outstanding request at a time, runs the AR/R or AW/W/B channel sequence, and returns read data or write completion as a one-cycle response pulse.
It sits inside ysyx_22050518, between the LSU/IFU arbiter and the io_master_* top-level ports.

Parameters:
ADDR_W, 32, address width of req_addr and io_master_a*addr
DATA_W, 64, data width; strobe width is DATA_W/8
ID_W, 4, AXI ID width
AXI_ID, 0, constant ID driven on awid/arid and expected on bid/rid

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  bridge idle, request accepted when req_valid && req_ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address, passed unaligned
req_size  input  3  AXI size code, 0..3 (1/2/4/8 bytes)
req_wdata  input  DATA_W  write data, already lane-aligned
req_wstrb  input  DATA_W/8  byte strobes
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_W  raw read lane, held until next rsp_valid
rsp_err  output  1  valid with rsp_valid; response error or protocol error
io_master_awvalid/awready  output/input  1  AW handshake
io_master_awaddr  output  ADDR_W  write address
io_master_awid/arid  output  ID_W  constant AXI_ID
io_master_awsize/arsize  output  3  registered req_size
io_master_awlen/arlen  output  8  constant 0
io_master_awburst/arburst  output  2  constant INCR (2'b01)
io_master_wvalid/wready  output/input  1  W handshake
io_master_wdata  output  DATA_W  registered req_wdata
io_master_wstrb  output  DATA_W/8  registered req_wstrb
io_master_wlast  output  1  equals wvalid
io_master_bvalid/bready  input/output  1  B handshake
io_master_bid, io_master_bresp  input  ID_W, 2  write response
io_master_arvalid/arready  output/input  1  AR handshake
io_master_araddr  output  ADDR_W  read address
io_master_rvalid/rready  input/output  1  R handshake
io_master_rid, io_master_rresp, io_master_rlast  input  ID_W, 2, 1  read response
io_master_rdata  input  DATA_W  read data

Behaviour:
- Reset values: FSM in IDLE. All valid and ready outputs are 0, except req_ready = 1. rsp_valid = 0, rsp_err = 0, rsp_rdata = 0. Address, data and strobe registers are 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - req_ready = 1. On acceptance, register addr, size, wdata and wstrb.
  - Go to RD_ADDR if req_we = 0, otherwise go to WR_REQ.
- RD_ADDR:
  - arvalid = 1, all fields stable, until arready. Then go to RD_DATA.
- RD_DATA:
  - rready = 1. On rvalid, register rdata.
  - rsp_err = (rresp != 0) || (rid != AXI_ID) || !rlast.
  - rsp_valid pulses on the next cycle, and the FSM is in IDLE that same cycle.
- WR_REQ:
  - awvalid and wvalid are both raised on entry.
  - Each drops independently after its own handshake. The order and same-cycle completion of AW and W are arbitrary.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready = 1. On bvalid: rsp_err = (bresp != 0) || (bid != AXI_ID). rsp_valid pulses on the next cycle, and the FSM returns to IDLE.
- Valid signals never drop before their handshake, and payloads never change while valid is high.
- Latency:
  - Request accepted at cycle 0.
  - arvalid/awvalid/wvalid are asserted at cycle 1 (registered).
  - For a zero-wait read (arready at 1, rvalid at 2), rsp_valid is at cycle 3 and a new request can be accepted at cycle 3.
- req_valid while busy is ignored (req_ready = 0). rsp_valid has no backpressure.
- rvalid/bvalid arriving outside RD_DATA/WR_RESP is ignored, since rready/bready are 0 there.
- Reset asserted mid-transaction: the FSM returns to IDLE on the next edge and all valids drop. The transaction is abandoned and no rsp_valid is issued. The responder shares the reset.

Decomposition:
- Package ysyx_22050518_axi_pkg holds:
  - the state enum;
  - the BURST_INCR and RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - the AXI_ID default.
- No sub-module: a single FSM plus registers.

Test Plan:
- Read: req_addr = 0x8000_0010, size 3, responder returns rdata 0x1122334455667788 with OKAY → araddr 0x80000010, arlen 0, arburst 1; rsp_valid pulses once 1 cycle after the R handshake with that data and rsp_err = 0.
- Write with W accepted before AW: wdata 0xDEADBEEF, wstrb 0x0F, wready at cycle 1, awready at cycle 4 → wvalid drops after cycle 1, awvalid held until cycle 4; OKAY B gives one rsp_valid with rsp_err = 0.
- Error responses: a read returning rresp SLVERR and a write returning bresp DECERR → rsp_err = 1 for each. A read returning rid = 5 with AXI_ID = 0 → rsp_err = 1.
- Backpressure: arready held low for 10 cycles → arvalid stays high with a stable araddr; req_ready stays 0 throughout, and a req_valid raised meanwhile is not accepted.
- Reset in WR_RESP: reset pulse before bvalid → next cycle all valids are 0 and req_ready = 1; a late bvalid produces no rsp_valid.
- Back-to-back: 100 random read/write requests against a zero-wait responder → each completes in 3 cycles, response order matches request order, and the data compares against a reference memory model.
